// File: rtl/ibus_line_buffer_if.sv
// Bus types shared by the fetch-side IBus and arbiter-side CBus, plus the
// interface bundling both ports of the line buffer.
package ibus_line_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam logic [2:0] MSIZE8         = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  // len codes are beats-1
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;
endpackage

interface ibus_line_buffer_if;
  import ibus_line_buffer_pkg::*;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport slave  (input ireq, output iresp, output oreq, input oresp);
  modport master (output ireq, input iresp, input oreq, output oresp);
endinterface

// File: rtl/ibus_line_buffer.sv
// One-line instruction buffer: combinational hits, a miss refills the whole
// line with a single read INCR burst on CBus.
module ibus_line_buffer
  import ibus_line_buffer_pkg::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  ibus_line_buffer_if.slave bus
);
  localparam int CW  = $clog2(LINE_BEATS);
  localparam int OFS = CW + 3;
  localparam int TW  = 64 - OFS;

  typedef enum logic {IDLE, FETCH} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic            buf_valid_q, buf_valid_d;
  logic [TW-1:0]   buf_tag_q, buf_tag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     line_addr_q, line_addr_d;
  logic            killed_q, killed_d;
  logic [63:0]     buf_data_q [LINE_BEATS];

  logic            hit, beat_we;
  logic [CW-1:0]   rd_beat;
  logic [63:0]     rd_word;

  wire unused_addr_lsb = ^bus.ireq.addr[1:0];

  always_comb begin
    fsm_d       = fsm_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    killed_d    = killed_q;
    bus.iresp   = '0;
    bus.oreq    = '0;

    rd_beat = bus.ireq.addr[OFS-1:3];
    rd_word = buf_data_q[rd_beat];
    // flush wins over a same-cycle hit so fence.i is never bypassed
    hit = (fsm_q == IDLE) && bus.ireq.valid && buf_valid_q &&
          (bus.ireq.addr[63:OFS] == buf_tag_q) && !flush;
    beat_we = (fsm_q == FETCH) && bus.oresp.ready;

    if (hit) begin
      bus.iresp.addr_ok = 1'b1;
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = bus.ireq.addr[2] ? rd_word[63:32] : rd_word[31:0];
    end

    unique case (fsm_q)
      IDLE: begin
        if (flush) buf_valid_d = 1'b0;
        if (bus.ireq.valid && !hit) begin
          fsm_d       = FETCH;
          line_addr_d = {bus.ireq.addr[63:OFS], {OFS{1'b0}}};
          buf_valid_d = 1'b0;
          cnt_d       = '0;
          killed_d    = 1'b0;
        end
      end
      FETCH: begin
        // request fields depend only on registered state, so they hold steady
        bus.oreq.valid = 1'b1;
        bus.oreq.size  = MSIZE8;
        bus.oreq.addr  = line_addr_q;
        bus.oreq.len   = 4'(LINE_BEATS - 1);
        bus.oreq.burst = AXI_BURST_INCR;
        if (flush) killed_d = 1'b1;
        if (bus.oresp.ready) begin
          cnt_d = cnt_q + 1'b1;
          if (bus.oresp.last) begin
            fsm_d       = IDLE;
            buf_tag_d   = line_addr_q[63:OFS];
            // an early last leaves the line invalid so the fetch retries
            buf_valid_d = (cnt_q == CW'(LINE_BEATS - 1)) && !killed_q && !flush;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      cnt_q       <= '0;
      line_addr_q <= '0;
      killed_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      killed_q    <= killed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_we) buf_data_q[cnt_q] <= bus.oresp.data;
  end
endmodule

// File: tb/tb_ibus_line_buffer.sv
// Randomized + directed bench for ibus_line_buffer against a line-level
// behavioural model; the bench also plays the CBus memory.
module tb_ibus_line_buffer;
  import ibus_line_buffer_pkg::*;
  localparam int LB     = 4;
  localparam int LBYTES = 8 * LB;

  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  ibus_line_buffer_if bif();

  ibus_line_buffer #(.LINE_BEATS(LB)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bif.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model: is a line resident, which one, its words, and the burst in flight
  bit          m_busy, m_valid, m_flushed, force_early;
  logic [63:0] m_addr, m_line_addr;
  logic [63:0] m_line [LB];
  int          m_beats, m_last_beat;
  int          early_pct = 0, flush_pct = 0;
  bit          obs_hit, obs_ov;
  logic [63:0] obs_oaddr;

  function automatic logic [63:0] mem(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0] + 32'h0001_3579};
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_flushed = 0; m_line_addr = '0; m_addr = '0; m_beats = 0;
  endtask

  task automatic set_req(input bit v, input logic [63:0] a);
    bif.ireq.valid = v;
    bif.ireq.addr  = a;
  endtask

  // called at posedge+1 with ireq/flush already applied; returns at next posedge+1
  task automatic cycle(input int rdy_pct);
    logic rdy, lst, fl, hit;
    logic [63:0] dat, w;
    ibus_req_t  rq;
    ibus_resp_t er;
    cbus_req_t  eo;
    rdy = 0; lst = 0; dat = '0;
    if (m_busy && (int'($urandom_range(99)) < rdy_pct)) begin
      rdy = 1;
      dat = mem(m_addr + 64'(8 * m_beats));
      lst = (m_beats == m_last_beat);
    end
    bif.oresp.ready = rdy;
    bif.oresp.last  = lst;
    bif.oresp.data  = dat;
    #3;
    rq = bif.ireq;
    fl = flush;
    hit = !m_busy && rq.valid && m_valid && !fl &&
          ((rq.addr & ~64'(LBYTES - 1)) == m_line_addr);
    er = '0;
    if (hit) begin
      w = m_line[int'((rq.addr >> 3) & 64'(LB - 1))];
      er.addr_ok = 1'b1;
      er.data_ok = 1'b1;
      er.data    = rq.addr[2] ? w[63:32] : w[31:0];
    end
    eo = '0;
    if (m_busy) begin
      eo.valid = 1'b1;
      eo.size  = MSIZE8;
      eo.addr  = m_addr;
      eo.len   = MLEN4;
      eo.burst = AXI_BURST_INCR;
    end
    chk("iresp", 160'(bif.iresp), 160'(er));
    chk("oreq", 160'(bif.oreq), 160'(eo));
    obs_hit   = bif.iresp.data_ok;
    obs_ov    = bif.oreq.valid;
    obs_oaddr = bif.oreq.addr;
    @(posedge clk);
    if (!m_busy) begin
      if (fl) m_valid = 0;
      if (rq.valid && !hit) begin
        m_busy = 1; m_valid = 0; m_beats = 0; m_flushed = 0;
        m_addr = rq.addr & ~64'(LBYTES - 1);
        if (force_early) m_last_beat = 1;
        else if (int'($urandom_range(99)) < early_pct) m_last_beat = int'($urandom_range(LB - 2));
        else m_last_beat = LB - 1;
        force_early = 0;
      end
    end else begin
      if (fl) m_flushed = 1;
      if (rdy) begin
        m_line[m_beats] = dat;
        m_beats++;
        if (lst) begin
          m_busy      = 0;
          m_line_addr = m_addr;
          m_valid     = (m_beats == LB) && !m_flushed;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_busy; i++) cycle(100);
    chk("drain_done", 160'(m_busy), 160'(0));
  endtask

  initial begin
    int n;
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    model_reset();
    force_early = 0;
    bif.oresp = '0;
    set_req(1, 64'h8000_0004);
    #12;
    chk("rst_oreq", 160'(bif.oreq), 160'(0));
    chk("rst_iresp", 160'(bif.iresp), 160'(0));
    #9;
    reset = 1'b1;

    // first fetch: miss, four back-to-back beats, hit LB+1 cycles later
    n = 0;
    cycle(100);
    while (!obs_hit && n < 20) begin n++; cycle(100); end
    chk("miss_lat", 160'(n), 160'(LB + 1));

    // sequential hits across the rest of the line
    for (int a = 8; a < LBYTES; a += 4) begin
      set_req(1, 64'h8000_0000 + 64'(a));
      cycle(100);
      chk("seq_hit", 160'(obs_hit), 160'(1));
      chk("seq_no_oreq", 160'(obs_ov), 160'(0));
    end

    // stalled burst
    set_req(1, 64'h8000_0044);
    cycle(100);
    foreach (pat[i]) cycle(pat[i] * 100);
    cycle(100);
    chk("stall_hit", 160'(obs_hit), 160'(1));

    // flush in the second beat cycle discards the line
    set_req(1, 64'h8000_0088);
    cycle(100);
    cycle(100);
    flush = 1'b1;
    cycle(100);
    flush = 1'b0;
    drain();
    cycle(100);
    chk("flush_nohit", 160'(obs_hit), 160'(0));
    cycle(100);
    chk("flush_refetch", 160'(obs_ov), 160'(1));
    drain();
    cycle(100);
    chk("flush_hit2", 160'(obs_hit), 160'(1));

    // early last on beat 2 of 4
    force_early = 1;
    set_req(1, 64'h8000_00CC);
    cycle(100);
    drain();
    cycle(100);
    chk("early_nohit", 160'(obs_hit), 160'(0));
    cycle(100);
    chk("early_readdr", 160'(obs_oaddr), 160'(64'h8000_00C0));
    drain();
    cycle(100);
    chk("early_hit2", 160'(obs_hit), 160'(1));

    // randomized traffic over a few neighbouring lines
    early_pct = 10;
    flush_pct = 4;
    for (int i = 0; i < 3000; i++) begin
      set_req(($urandom_range(99) < 85),
              64'h8000_0000 + 64'($urandom_range(3) * LBYTES) + 64'($urandom_range(LBYTES - 1)));
      flush = ($urandom_range(99) < 32'(flush_pct));
      cycle(60);
    end
    flush = 1'b0;
    early_pct = 0;
    set_req(0, '0);
    cycle(100);
    drain();

    // async reset in the middle of a burst
    set_req(1, 64'h8000_0104);
    cycle(100);
    cycle(100);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_oreq_valid", 160'(bif.oreq.valid), 160'(0));
    chk("arst_iresp", 160'(bif.iresp), 160'(0));
    bif.oresp = '0;
    set_req(0, '0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(100);
    chk("arst_idle", 160'(obs_ov), 160'(0));
    set_req(1, 64'h8000_0104);
    cycle(100);
    chk("arst_remiss", 160'(obs_hit), 160'(0));
    drain();
    cycle(100);
    chk("arst_hit", 160'(obs_hit), 160'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
